alu48_seq: RTL and testbench
============================

# alu48_seq

Multi-cycle unsigned multiply/divide sequencer built on the shared 48-bit ALU. It accepts one request at a time through a valid/ready handshake. It then borrows the ALU for exactly 48 cycles, issuing one ADD (multiply) or SUB (divide) per cycle, and returns the result through a second valid/ready handshake. The block sits beside the ALU in the execute stage. While `alu_own` is high, top-level muxing routes the ALU inputs from this block.

## Interface
- No parameters. Data width is fixed at 48; the iteration count is fixed at 48.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `kill` in 1: synchronous abort; returns to IDLE and drops any pending response.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 2: 00 = MUL (low 48 bits of the product), 01 = DIVU, 1x = illegal.
- `req_a` in 48: multiplicand / dividend.
- `req_b` in 48: multiplier / divisor.
- `req_tag` in 4: echoed on the response.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: consumer accepts.
- `rsp_lo` out 48: product or quotient.
- `rsp_hi` out 48: remainder for DIVU; 0 for MUL.
- `rsp_tag` out 4: the request's tag.
- `rsp_dz` out 1: divide-by-zero flag.
- `rsp_err` out 1: illegal op flag.
- `alu_own` out 1: high in RUN; requests the ALU.
- `alu_a` out 48, `alu_b` out 48: ALU operands.
- `alu_op` out 6: 0x00 ADD or 0x01 SUB.
- `alu_shamt` out 6: always 0.
- `alu_y` in 48: ALU result.
- `alu_lt_u` in 1: ALU unsigned A<B.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** `req_ready`=1. On `req_valid`, latch op, a, b and tag, and clear `cnt`.
  - op 1x: go to DONE with `rsp_err`=1, `rsp_lo`=`rsp_hi`=0.
  - DIVU with b==0: go to DONE with `rsp_dz`=1, `rsp_lo`=48'hFFFF_FFFF_FFFF, `rsp_hi`=a.
  - Otherwise: go to RUN.
- **MUL, RUN step:**
  - Drive `alu_op`=ADD, `alu_a`=acc, `alu_b` = mplier[0] ? mcand : 0.
  - Update acc<=`alu_y`, mcand<=mcand<<1, mplier<=mplier>>1.
  - Initial values: acc=0, mcand=a, mplier=b.
  - Overflow beyond bit 47 is discarded.
- **DIVU, RUN step (restoring):**
  - Form sh = {rem[46:0], quo[47]}. Drive `alu_op`=SUB, `alu_a`=sh, `alu_b`=divisor.
  - take = rem[47] | ~`alu_lt_u`. The rem[47] term covers the case where the true shifted value exceeds 48 bits.
  - rem <= take ? `alu_y` : sh; quo <= {quo[46:0], take}.
  - Initial values: rem=0, quo=dividend.
- `cnt` increments on each RUN cycle. The cycle with `cnt`==47 performs the final step and moves to DONE.
- **DONE:** `rsp_valid`=1 and all response fields are stable.
  - MUL: `rsp_lo`=acc, `rsp_hi`=0.
  - DIVU: `rsp_lo`=quo, `rsp_hi`=rem.
  - On `rsp_ready`, go to IDLE. There is no DONE→RUN bypass, so there is one bubble cycle between jobs.
- **ALU outputs outside RUN:** `alu_a`=`alu_b`=0, `alu_op`=ADD, `alu_own`=0. These outputs are combinational from state and registers.
- **`kill`:** takes priority over all transitions in every state.
  - Next state is IDLE and `rsp_valid` drops next cycle.
  - If `kill` coincides with `req_valid` in IDLE, the request is not accepted (`req_ready` is gated by ~`kill`).

## Timing
- Reset (async assert, sync-safe deassert) puts the block in IDLE with:
  - `req_ready`=1;
  - `rsp_valid`=0;
  - `rsp_lo`=`rsp_hi`=0, `rsp_tag`=0, `rsp_dz`=`rsp_err`=0;
  - `alu_own`=0;
  - all internal registers 0.
- Reset mid-RUN abandons the job with no response.
- Let edge E be the edge at which the request is accepted:
  - RUN occupies the 48 cycles after E;
  - `rsp_valid` rises 49 cycles after E;
  - minimum request-to-request spacing is 50 cycles.
- Divide-by-zero and illegal op: `rsp_valid` rises 1 cycle after E.
- `alu_y` and `alu_lt_u` are sampled in the same cycle that the operands are driven; the ALU is purely combinational.
- `rsp_*` must not change while `rsp_valid`=1 and `rsp_ready`=0.

## Test plan
- MUL a=3, b=5, tag=7:
  - `rsp_valid` rises exactly 49 cycles after accept;
  - response `rsp_lo`=15, `rsp_hi`=0, `rsp_tag`=7;
  - `alu_own` is high for exactly 48 cycles.
- MUL a=48'hFFFF_FFFF_FFFF, b=2 → `rsp_lo`=48'hFFFF_FFFF_FFFE (wrap).
- DIVU checks:
  - 100/7 → `rsp_lo`=14, `rsp_hi`=2.
  - 48'hFFFF_FFFF_FFFF / 48'h8000_0000_0001 → `rsp_lo`=1, `rsp_hi`=48'h7FFF_FFFF_FFFE (exercises the rem[47] path).
- DIVU 42/0 → 1 cycle later `rsp_dz`=1, `rsp_lo`=all ones, `rsp_hi`=42, `alu_own` never high. Separately, op=2'b10 → `rsp_err`=1 one cycle after accept.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in DONE → outputs stable and `req_ready`=0. Release → IDLE, and the next request is accepted one cycle later.
- Abort during RUN:
  - `kill` at `cnt`=20 → IDLE next cycle, no response, `req_ready`=1.
  - `rst_n` low at `cnt`=30 → all outputs at reset values immediately.
  - A following MUL 6×7 → 42.

Source files
------------

// File: rtl/alu48_seq_if.sv
// Bundle of request/response handshakes and ALU borrow signals for alu48_seq.
// Handshake rule, both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. Once raised, valid and its payload
// hold steady until that transfer happens.
interface alu48_seq_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [47:0] req_a;
  logic [47:0] req_b;
  logic [3:0]  req_tag;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [47:0] rsp_lo;
  logic [47:0] rsp_hi;
  logic [3:0]  rsp_tag;
  logic        rsp_dz;
  logic        rsp_err;
  // shared ALU access
  logic        alu_own;
  logic [47:0] alu_a;
  logic [47:0] alu_b;
  logic [5:0]  alu_op;
  logic [5:0]  alu_shamt;
  logic [47:0] alu_y;
  logic        alu_lt_u;
  // sequencer state, exposed for debug
  logic [1:0]  dbg_state;

  // environment side: issues requests, consumes responses, provides the ALU
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready, alu_y, alu_lt_u,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag, rsp_dz, rsp_err,
    input  alu_own, alu_a, alu_b, alu_op, alu_shamt, dbg_state
  );

  // sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready, alu_y, alu_lt_u,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag, rsp_dz, rsp_err,
    output alu_own, alu_a, alu_b, alu_op, alu_shamt, dbg_state
  );
endinterface

// File: rtl/alu48_seq.sv
// Multi-cycle unsigned 48-bit multiply / divide sequencer. It borrows the
// shared ALU for 48 cycles per job: shift-add for MUL and restoring division
// for DIVU. Divide-by-zero and illegal ops finish without using the ALU.
module alu48_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill,
  alu48_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] ALU_ADD  = 6'h00;
  localparam logic [5:0] ALU_SUB  = 6'h01;
  localparam logic [5:0] LAST_CNT = 6'd47;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        err_q, err_d;
  logic        dz_q, dz_d;
  logic [3:0]  tag_q, tag_d;
  // r0: MUL accumulator / DIVU remainder
  // r1: MUL multiplicand / DIVU quotient (starts as the dividend)
  // r2: MUL multiplier / DIVU divisor
  logic [47:0] r0_q, r0_d;
  logic [47:0] r1_q, r1_d;
  logic [47:0] r2_q, r2_d;

  logic        accept;
  logic [47:0] div_sh;
  logic        div_take;

  assign accept   = bus.req_valid && bus.req_ready;
  // The shifted partial remainder is 49 bits wide. r0_q[47] is its MSB, and
  // when it is set the value is at least the divisor, whatever the ALU
  // compare says about the low 48 bits.
  assign div_sh   = {r0_q[46:0], r1_q[47]};
  assign div_take = r0_q[47] | ~bus.alu_lt_u;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
      tag_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
      tag_q   <= tag_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
    end
  end

  // ALU operand drive; depends only on state and registers
  always_comb begin
    bus.alu_own   = 1'b0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_op    = ALU_ADD;
    bus.alu_shamt = '0;
    if (state_q == S_RUN) begin
      bus.alu_own = 1'b1;
      if (div_q) begin
        bus.alu_a  = div_sh;
        bus.alu_b  = r2_q;
        bus.alu_op = ALU_SUB;
      end else begin
        bus.alu_a  = r0_q;
        bus.alu_b  = r2_q[0] ? r1_q : '0;
        bus.alu_op = ALU_ADD;
      end
    end
  end

  // Next-state and datapath update; kill overrides every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    err_d   = err_q;
    dz_d    = dz_q;
    tag_d   = tag_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_d = bus.req_tag;
          cnt_d = '0;
          div_d = (bus.req_op == 2'b01);
          err_d = bus.req_op[1];
          dz_d  = (bus.req_op == 2'b01) && (bus.req_b == '0);
          if (bus.req_op[1]) begin
            r0_d    = '0;
            r1_d    = '0;
            r2_d    = '0;
            state_d = S_DONE;
          end else if ((bus.req_op == 2'b01) && (bus.req_b == '0)) begin
            r0_d    = bus.req_a;
            r1_d    = '1;
            r2_d    = '0;
            state_d = S_DONE;
          end else begin
            r0_d    = '0;
            r1_d    = bus.req_a;
            r2_d    = bus.req_b;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (div_q) begin
          r0_d = div_take ? bus.alu_y : div_sh;
          r1_d = {r1_q[46:0], div_take};
        end else begin
          r0_d = bus.alu_y;
          r1_d = {r1_q[46:0], 1'b0};
          r2_d = {1'b0, r2_q[47:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) && !kill;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_lo    = (state_q == S_DONE) ? (div_q ? r1_q : r0_q) : '0;
  assign bus.rsp_hi    = ((state_q == S_DONE) && div_q) ? r0_q : '0;
  assign bus.rsp_tag   = tag_q;
  assign bus.rsp_dz    = dz_q;
  assign bus.rsp_err   = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu48_seq.sv
// Testbench for alu48_seq: combinational ALU model, directed scenarios and
// randomized jobs checked against a plain-arithmetic reference model.
module tb_alu48_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kill = 1'b0;

  always #5 clk = ~clk;

  alu48_seq_if bus();

  alu48_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (kill),
    .bus   (bus)
  );

  // Shared 48-bit ALU, purely combinational
  always_comb begin
    bus.alu_y    = (bus.alu_op == 6'h01) ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);
    bus.alu_lt_u = (bus.alu_a < bus.alu_b);
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [101:0] exp_q[$];

  // Expected response packed as {err, dz, tag, hi, lo}
  function automatic logic [101:0] model(input logic [1:0] op, input logic [47:0] a,
                                         input logic [47:0] b, input logic [3:0] tag);
    logic [95:0] p;
    if (op[1]) return {1'b1, 1'b0, tag, 48'd0, 48'd0};
    if (op == 2'b00) begin
      p = {48'd0, a} * {48'd0, b};
      return {1'b0, 1'b0, tag, 48'd0, p[47:0]};
    end
    if (b == 48'd0) return {1'b0, 1'b1, tag, a, 48'hFFFF_FFFF_FFFF};
    return {1'b0, 1'b0, tag, a % b, a / b};
  endfunction

  function automatic logic [101:0] rsp_now();
    return {bus.rsp_err, bus.rsp_dz, bus.rsp_tag, bus.rsp_hi, bus.rsp_lo};
  endfunction

  function automatic logic [212:0] all_outs();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_lo, bus.rsp_hi, bus.rsp_tag,
            bus.rsp_dz, bus.rsp_err, bus.alu_own, bus.alu_a, bus.alu_b,
            bus.alu_op, bus.alu_shamt};
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [47:0] b);
    if (op[1] || (op == 2'b01 && b == 48'd0)) return 1;
    return 49;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [1:0] op, input logic [47:0] a,
                           input logic [47:0] b, input logic [3:0] tag);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    exp_q.push_back(model(op, a, b, tag));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts cycles after accept until rsp_valid, and cycles with alu_own high
  task automatic wait_rsp(output int cyc, output int own);
    cyc = 0;
    own = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.alu_own) own++;
    end while (!bus.rsp_valid && cyc < 200);
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [212:0] exp_v;
    exp_v = '0;
    exp_v[212] = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_outs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", all_outs(), exp_v);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_mul_basic();
    int cyc, own;
    logic [101:0] e;
    drive_req(2'b00, 48'd3, 48'd5, 4'd7);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 49) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d expected 49", cyc);
    end
    n_checks++;
    if (own !== 48) begin
      n_fail++;
      $display("FAIL mul_alu_own_cycles: got %0d expected 48", own);
    end
    n_checks++;
    if (rsp_now() !== e) begin
      n_fail++;
      $display("FAIL mul_3x5: got %h expected %h", rsp_now(), e);
    end
    release_rsp();
  endtask

  task automatic test_mul_wrap();
    int cyc, own;
    logic [101:0] e;
    drive_req(2'b00, 48'hFFFF_FFFF_FFFF, 48'd2, 4'd1);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (rsp_now() !== e || bus.rsp_lo !== 48'hFFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL mul_wrap: got %h expected %h", rsp_now(), e);
    end
    release_rsp();
  endtask

  task automatic test_div();
    int cyc, own;
    logic [101:0] e;
    drive_req(2'b01, 48'd100, 48'd7, 4'd2);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (rsp_now() !== e || bus.rsp_lo !== 48'd14 || bus.rsp_hi !== 48'd2 || cyc !== 49) begin
      n_fail++;
      $display("FAIL div_100_7: got %h cyc %0d expected %h cyc 49", rsp_now(), cyc, e);
    end
    release_rsp();
    drive_req(2'b01, 48'hFFFF_FFFF_FFFF, 48'h8000_0000_0001, 4'd3);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (rsp_now() !== e || bus.rsp_lo !== 48'd1 || bus.rsp_hi !== 48'h7FFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL div_rem47: got %h expected %h", rsp_now(), e);
    end
    release_rsp();
  endtask

  task automatic test_div_zero_illegal();
    int cyc, own;
    logic [101:0] e;
    drive_req(2'b01, 48'd42, 48'd0, 4'd9);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 1 || own !== 0) begin
      n_fail++;
      $display("FAIL divzero_timing: got cyc %0d own %0d expected 1 0", cyc, own);
    end
    n_checks++;
    if (rsp_now() !== e) begin
      n_fail++;
      $display("FAIL divzero_rsp: got %h expected %h", rsp_now(), e);
    end
    release_rsp();
    drive_req(2'b10, 48'd11, 48'd13, 4'd5);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 1 || own !== 0 || rsp_now() !== e) begin
      n_fail++;
      $display("FAIL illegal_op: got cyc %0d own %0d rsp %h expected 1 0 %h", cyc, own, rsp_now(), e);
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    int cyc, own;
    logic [101:0] e;
    drive_req(2'b00, 48'h1234_5678, 48'h9ABC, 4'd4);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_now() !== e || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got %h v=%b rdy=%b expected %h v=1 rdy=0",
                 i, rsp_now(), bus.rsp_valid, bus.req_ready, e);
      end
    end
    release_rsp();
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: req_ready got %b expected 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 48'd9;
    bus.req_b     = 48'd11;
    bus.req_tag   = 4'd12;
    exp_q.push_back(model(2'b00, 48'd9, 48'd11, 4'd12));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 49 || rsp_now() !== e) begin
      n_fail++;
      $display("FAIL backpressure_next: got cyc %0d rsp %h expected 49 %h", cyc, rsp_now(), e);
    end
    release_rsp();
  endtask

  task automatic test_kill();
    int seen;
    drive_req(2'b00, 48'd123, 48'd456, 4'd6);
    repeat (21) @(negedge clk);
    n_checks++;
    if (bus.alu_own !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_pre_run: alu_own got %b expected 1", bus.alu_own);
    end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_own !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_to_idle: rdy=%b v=%b own=%b expected 1 0 0", bus.req_ready, bus.rsp_valid, bus.alu_own);
    end
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL kill_no_rsp: rsp_valid cycles got %0d expected 0", seen);
    end
    // kill together with a request in IDLE blocks the accept
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 48'd2;
    bus.req_b     = 48'd2;
    kill = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    kill = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.alu_own !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_blocks_accept: own=%b rdy=%b expected 0 1", bus.alu_own, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, own;
    logic [101:0] e;
    logic [212:0] exp_v;
    exp_v = '0;
    exp_v[212] = 1'b1;
    drive_req(2'b01, 48'hABCD_EF01_2345, 48'd77, 4'd15);
    repeat (31) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    n_checks++;
    if (all_outs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h expected %h", all_outs(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(2'b00, 48'd6, 48'd7, 4'd3);
    wait_rsp(cyc, own);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 49 || rsp_now() !== e || bus.rsp_lo !== 48'd42) begin
      n_fail++;
      $display("FAIL after_reset_mul: got cyc %0d rsp %h expected 49 %h", cyc, rsp_now(), e);
    end
    release_rsp();
  endtask

  task automatic test_random();
    int cyc, own, sel, lat;
    logic [1:0] op;
    logic [63:0] ta, tb;
    logic [47:0] a, b;
    logic [3:0] tag;
    logic [101:0] e;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ta  = {$urandom(), $urandom()};
      tb  = {$urandom(), $urandom()};
      a   = ta[47:0] >> $urandom_range(0, 40);
      b   = tb[47:0] >> $urandom_range(0, 47);
      tag = 4'($urandom_range(0, 15));
      if (sel < 4) op = 2'b00;
      else if (sel < 8) op = 2'b01;
      else if (sel == 8) begin op = 2'b01; b = 48'd0; end
      else op = {1'b1, 1'($urandom_range(0, 1))};
      lat = exp_latency(op, b);
      drive_req(op, a, b, tag);
      wait_rsp(cyc, own);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc !== lat || rsp_now() !== e) begin
        n_fail++;
        $display("FAIL random[%0d]: op %0d a %h b %h got cyc %0d rsp %h expected cyc %0d rsp %h",
                 i, op, a, b, cyc, rsp_now(), lat, e);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_rsp();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_mul_basic();
    test_mul_wrap();
    test_div();
    test_div_zero_illegal();
    test_backpressure();
    test_kill();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
